vert_ucode_quicksort_asm: RTL and testbench
===========================================

Name: vert_ucode_quicksort_asm

Overview:
Sequential micro-assembler and program loader for the vertical-microcode quicksort engine. It accepts one symbolic instruction per handshake (mnemonic plus operand fields), encodes it into the 16-bit instruction word the sequencer decodes, and writes it into the ucode instruction RAM at consecutive PCs. It sits between the host/testbench program-load path and the ucode RAM write port, and reports completion, instruction count and errors.

Parameters:
PC_W, 8, instruction address width (pc_t)
INST_W, 16, encoded instruction width (4-bit opcode + 12-bit body)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
start  in  1  pulse; begin a program load at base_pc (accepted only in IDLE)
base_pc  in  8  first PC written
cmd_vld  in  1  symbolic instruction valid
cmd_rdy  out  1  asm can accept cmd this cycle
cmd_op  in  5  mnemonic: 0 NOP,1 JCC,2 PUSH,3 POP,4 LD,5 ST,6 MOV,7 MOVI,8 MOVS,9 ADD,10 ADDI,11 SUB,12 SUBI,13 CALL,14 RET,15 EMIT,16 WAIT; others invalid
cmd_dst  in  3  dst register (reg_t)
cmd_src0  in  3  src0 register
cmd_src1  in  3  src1 register / special selector
cmd_imm  in  3  immediate
cmd_wren  in  1  ARITH writeback enable (0 = compare only)
cmd_cc  in  2  JCC condition (UNCOND/EQ/GT/LE)
cmd_tgt  in  8  JCC/CALL target
cmd_last  in  1  final instruction of program
mem_we  out  1  ucode RAM write strobe
mem_rdy  in  1  RAM accepts write this cycle
mem_addr  out  8  RAM write address
mem_wdata  out  16  encoded instruction
done  out  1  one-cycle pulse: program committed
count  out  9  instructions written in current/last load
error  out  1  sticky; invalid op or PC overflow; cleared by start

Behaviour:
- Reset (rst==0 at posedge): state IDLE; cmd_rdy=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, count=0, error=0.
- States: IDLE -> (start) LOAD -> (cmd_last accepted) DRAIN -> (output reg empty) DONE -> IDLE (one cycle, done=1).
- start outside IDLE ignored. start in IDLE: pc<=base_pc, count<=0, error<=0.
- cmd_rdy = (state==LOAD) && (output reg empty || mem_rdy) && !overflow. Transfer on cmd_vld&&cmd_rdy.
- Single output register: accepted cmd is encoded combinationally and registered; mem_we asserts the cycle after acceptance, holds addr/wdata stable until mem_we&&mem_rdy. Back-to-back throughput 1/cycle with mem_rdy high.
- Encoding: [15:12] opcode, [11] SEL, [10:8] R, [7] W, [6:4] S, [3] IMM, [2:0] U/I; [9:8]=CC, [7:0]=A for JCC/CALL. Unused bits 0.
  NOP 0x0000. JCC {1,00,cc,tgt}. PUSH {2,0,000,00000,src1}. POP {2,1,dst,0x00}. LD {4,0,dst,00000,src1}. ST {4,1,000,0,src0,0,src1}. MOV {6,0,dst,0000,0,src1}. MOVI {6,0,dst,0000,1,imm}. MOVS {6,1,dst,0000,0,src1}. ADD/ADDI/SUB/SUBI {7,sub,dst,wren,src0,isimm,src1|imm}. CALL {C,0,000,tgt}. RET {C,1,000,0x00}. EMIT {F,0,0x000}. WAIT {F,1,0x000}.
- Invalid cmd_op: cmd consumed, no write, pc/count unchanged, error<=1; cmd_last still honoured.
- PC: increments per written instruction, 8-bit. Write at 0xFF allowed; next valid cmd is an overflow: cmd_rdy deasserts for the remainder of LOAD, error<=1, FSM goes to DRAIN then DONE (no wrap to 0x00).
- count increments on each mem_we&&mem_rdy; 9 bits so 256 fits.
- cmd_last with invalid op in same cycle: no write, go to DRAIN.
- rst low mid-load: everything returns to reset values next edge; in-flight write dropped.

Test Plan:
- start base_pc=0x10; ADDI dst=R2 src0=R1 imm=3 wren=1, last -> one write addr 0x10 data 0x729B; done 2 cycles after mem handshake; count=1.
- SUB dst=0 src0=R3 src1=R4 wren=0; JCC GT tgt=0x1A; CALL 0x40; RET; POP R5(last), mem_rdy=1 -> data 0x7834,0x121A,0xC040,0xC800,0x2D00 at consecutive PCs, 1/cycle, count=5.
- mem_rdy held low 3 cycles mid-stream -> mem_addr/wdata stable, cmd_rdy=0, no loss or duplication.
- cmd_op=20 between two valid cmds -> error=1, only 2 writes, PCs contiguous.
- base_pc=0xFE, 3 cmds -> writes 0xFE,0xFF; third rejected, error=1, done pulses, count=2.
- rst low during LOAD with pending write -> mem_we=0, state IDLE, count=0 next cycle; new start works.

Source files
------------

// File: rtl/vert_ucode_quicksort_asm.sv
// Micro-assembler and loader for the vertical-microcode quicksort engine.
// Ports: clk/rst (sync, active-low), start/base_pc open a load,
//   cmd_* is one symbolic instruction per vld/rdy handshake,
//   mem_* is the ucode RAM write port (we/rdy handshake),
//   done pulses on commit, count = words written, error is sticky.
module vert_ucode_quicksort_asm #(
   parameter int PC_W   = 8,
   parameter int INST_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [PC_W-1:0]   base_pc,
   input  logic              cmd_vld,
   output logic              cmd_rdy,
   input  logic [4:0]        cmd_op,
   input  logic [2:0]        cmd_dst,
   input  logic [2:0]        cmd_src0,
   input  logic [2:0]        cmd_src1,
   input  logic [2:0]        cmd_imm,
   input  logic              cmd_wren,
   input  logic [1:0]        cmd_cc,
   input  logic [PC_W-1:0]   cmd_tgt,
   input  logic              cmd_last,
   output logic              mem_we,
   input  logic              mem_rdy,
   output logic [PC_W-1:0]   mem_addr,
   output logic [INST_W-1:0] mem_wdata,
   output logic              done,
   output logic [PC_W:0]     count,
   output logic              error
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state;

   // Extra MSB marks "one past the last PC": a write at the top
   // address has happened and nothing more may be placed.
   logic [PC_W:0]     pc;
   logic              ovf;
   logic              xfer;
   logic              op_ok;
   logic              is_sub;
   logic              is_imm;
   logic [INST_W-1:0] enc;

   assign ovf     = pc[PC_W];
   assign cmd_rdy = (state == LOAD) && (!mem_we || mem_rdy) && !ovf;
   assign xfer    = cmd_vld && cmd_rdy;

   assign is_sub = (cmd_op == 5'd11) || (cmd_op == 5'd12);
   assign is_imm = (cmd_op == 5'd10) || (cmd_op == 5'd12);

   always_comb begin
      enc   = '0;
      op_ok = 1'b1;
      case (cmd_op)
         5'd0:  enc = '0;
         5'd1:  enc = {4'h1, 2'b00, cmd_cc, cmd_tgt};
         5'd2:  enc = {4'h2, 1'b0, 3'b000, 5'b00000, cmd_src1};
         5'd3:  enc = {4'h2, 1'b1, cmd_dst, 8'h00};
         5'd4:  enc = {4'h4, 1'b0, cmd_dst, 5'b00000, cmd_src1};
         5'd5:  enc = {4'h4, 1'b1, 3'b000, 1'b0, cmd_src0,
                       1'b0, cmd_src1};
         5'd6:  enc = {4'h6, 1'b0, cmd_dst, 4'h0, 1'b0, cmd_src1};
         5'd7:  enc = {4'h6, 1'b0, cmd_dst, 4'h0, 1'b1, cmd_imm};
         5'd8:  enc = {4'h6, 1'b1, cmd_dst, 4'h0, 1'b0, cmd_src1};
         5'd9, 5'd10, 5'd11, 5'd12:
            enc = {4'h7, is_sub, cmd_dst, cmd_wren, cmd_src0,
                   is_imm, is_imm ? cmd_imm : cmd_src1};
         5'd13: enc = {4'hC, 1'b0, 3'b000, cmd_tgt};
         5'd14: enc = {4'hC, 1'b1, 3'b000, 8'h00};
         5'd15: enc = {4'hF, 1'b0, 11'h000};
         5'd16: enc = {4'hF, 1'b1, 11'h000};
         default: op_ok = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         pc        <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         done      <= 1'b0;
         count     <= '0;
         error     <= 1'b0;
      end else begin
         done <= 1'b0;
         // Retire the held word; a new accept below may refill it.
         if (mem_we && mem_rdy) begin
            mem_we <= 1'b0;
            count  <= count + 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  pc    <= {1'b0, base_pc};
                  count <= '0;
                  error <= 1'b0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (xfer) begin
                  if (op_ok) begin
                     mem_we    <= 1'b1;
                     mem_addr  <= pc[PC_W-1:0];
                     mem_wdata <= enc;
                     pc        <= pc + 1'b1;
                  end else begin
                     error <= 1'b1;
                  end
                  if (cmd_last) state <= DRAIN;
               end else if (ovf && cmd_vld) begin
                  // Program does not fit: refuse it and wrap up.
                  error <= 1'b1;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!mem_we) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vert_ucode_quicksort_asm.sv
// Bench for vert_ucode_quicksort_asm: directed programs, a program-level
// model of the expected RAM image, and a per-cycle compare process.
`timescale 1ns/1ps
module tb_vert_ucode_quicksort_asm;

   typedef struct packed {
      logic [4:0] op;
      logic [2:0] dst;
      logic [2:0] src0;
      logic [2:0] src1;
      logic [2:0] imm;
      logic       wren;
      logic [1:0] cc;
      logic [7:0] tgt;
      logic       last;
   } cmd_t;

   logic        clk = 0;
   logic        rst;
   logic        start;
   logic [7:0]  base_pc;
   logic        cmd_vld;
   logic        cmd_rdy;
   logic [4:0]  cmd_op;
   logic [2:0]  cmd_dst, cmd_src0, cmd_src1, cmd_imm;
   logic        cmd_wren;
   logic [1:0]  cmd_cc;
   logic [7:0]  cmd_tgt;
   logic        cmd_last;
   logic        mem_we;
   logic        mem_rdy;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        done;
   logic [8:0]  count;
   logic        error;

   vert_ucode_quicksort_asm dut (
      .clk(clk), .rst(rst), .start(start), .base_pc(base_pc),
      .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op),
      .cmd_dst(cmd_dst), .cmd_src0(cmd_src0), .cmd_src1(cmd_src1),
      .cmd_imm(cmd_imm), .cmd_wren(cmd_wren), .cmd_cc(cmd_cc),
      .cmd_tgt(cmd_tgt), .cmd_last(cmd_last), .mem_we(mem_we),
      .mem_rdy(mem_rdy), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .done(done), .count(count), .error(error)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_addr_q[$];
   logic [15:0] exp_data_q[$];
   logic [7:0]  log_addr[$];
   logic [15:0] log_data[$];
   int          exp_cnt, exp_acc;
   logic        exp_err;
   cmd_t        prog[$];

   int hs_seen = 0, cyc = 0, last_hs_cyc = 0, first_hs_cyc = -1;
   int done_seen = 0;
   int stall_left = 0;
   logic        prev_stall = 0, prev_done = 0;
   logic [7:0]  prev_addr;
   logic [15:0] prev_data;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic cmd_t mk(int op, int dst, int s0, int s1, int imm,
                               int wren, int cc, int tgt, int last);
      cmd_t c;
      c.op = 5'(op); c.dst = 3'(dst); c.src0 = 3'(s0);
      c.src1 = 3'(s1); c.imm = 3'(imm); c.wren = 1'(wren);
      c.cc = 2'(cc); c.tgt = 8'(tgt); c.last = 1'(last);
      return c;
   endfunction

   // Word layout from the ISA table: opcode<<12, SEL<<11, R<<8, W<<7,
   // S<<4, IMM<<3, U; A occupies the low byte for branches.
   function automatic logic [15:0] model_enc(cmd_t c);
      int v, sub, im;
      v = 0;
      case (int'(c.op))
         1:  v = (1 << 12) | (int'(c.cc) << 8) | int'(c.tgt);
         2:  v = (2 << 12) | int'(c.src1);
         3:  v = (2 << 12) | (1 << 11) | (int'(c.dst) << 8);
         4:  v = (4 << 12) | (int'(c.dst) << 8) | int'(c.src1);
         5:  v = (4 << 12) | (1 << 11) | (int'(c.src0) << 4)
                 | int'(c.src1);
         6:  v = (6 << 12) | (int'(c.dst) << 8) | int'(c.src1);
         7:  v = (6 << 12) | (int'(c.dst) << 8) | (1 << 3) | int'(c.imm);
         8:  v = (6 << 12) | (1 << 11) | (int'(c.dst) << 8)
                 | int'(c.src1);
         9, 10, 11, 12: begin
            sub = (c.op >= 11) ? 1 : 0;
            im  = (c.op == 10 || c.op == 12) ? 1 : 0;
            v = (7 << 12) | (sub << 11) | (int'(c.dst) << 8)
                | (int'(c.wren) << 7) | (int'(c.src0) << 4) | (im << 3)
                | (im != 0 ? int'(c.imm) : int'(c.src1));
         end
         13: v = (12 << 12) | int'(c.tgt);
         14: v = (12 << 12) | (1 << 11);
         15: v = 'hF000;
         16: v = 'hF800;
         default: v = 0;
      endcase
      return 16'(v);
   endfunction

   always @(posedge clk) begin
      #2;
      if (stall_left > 0) begin
         mem_rdy = 0;
         stall_left--;
      end else begin
         mem_rdy = 1;
      end
   end

   // Per-cycle compare against the program-level model.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         hs_seen = 0;
         prev_stall = 0;
         prev_done = 0;
         exp_addr_q.delete();
         exp_data_q.delete();
      end else begin
         chk("count_track", 32'(count), 32'(hs_seen));
         if (prev_stall) begin
            chk("hold_we", 32'(mem_we), 1);
            chk("hold_addr", 32'(mem_addr), 32'(prev_addr));
            chk("hold_data", 32'(mem_wdata), 32'(prev_data));
         end
         if (mem_we && !mem_rdy) chk("rdy_when_full", 32'(cmd_rdy), 0);
         if (mem_we && mem_rdy) begin
            if (exp_addr_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL write_unexpected: got %0h@%0h, expected none",
                        mem_wdata, mem_addr);
            end else begin
               chk("wr_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
               chk("wr_data", 32'(mem_wdata), 32'(exp_data_q.pop_front()));
            end
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            hs_seen++;
            last_hs_cyc = cyc;
            if (first_hs_cyc < 0) first_hs_cyc = cyc;
         end
         if (done) begin
            chk("done_pulse", 32'(prev_done), 0);
            chk("done_count", 32'(count), 32'(exp_cnt));
            chk("done_error", 32'(error), 32'(exp_err));
            chk("done_pending", 32'(exp_addr_q.size()), 0);
            if (first_hs_cyc >= 0)
               chk("done_latency", 32'(cyc - last_hs_cyc), 2);
            done_seen++;
         end
         prev_done = done;
         if (start) begin
            hs_seen = 0;
            first_hs_cyc = -1;
         end
         prev_stall = mem_we && !mem_rdy;
         prev_addr = mem_addr;
         prev_data = mem_wdata;
      end
   end

   task automatic drive(input cmd_t c);
      cmd_op = c.op; cmd_dst = c.dst; cmd_src0 = c.src0;
      cmd_src1 = c.src1; cmd_imm = c.imm; cmd_wren = c.wren;
      cmd_cc = c.cc; cmd_tgt = c.tgt; cmd_last = c.last;
      cmd_vld = 1;
   endtask

   task automatic send(input cmd_t c, output bit acc);
      drive(c);
      acc = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (cmd_rdy) begin
            acc = 1;
            break;
         end
         if (done) break;
      end
      if (acc) begin
         @(posedge clk);
         #1;
      end else begin
         cmd_vld = 0;
      end
   endtask

   task automatic run_prog(input logic [7:0] base, input int stall_at);
      int pc, d0, nacc;
      bit acc;
      exp_addr_q.delete();
      exp_data_q.delete();
      log_addr.delete();
      log_data.delete();
      pc = base; exp_acc = 0; exp_cnt = 0; exp_err = 0;
      foreach (prog[i]) begin
         if (pc > 255) begin
            exp_err = 1;
            break;
         end
         exp_acc++;
         if (prog[i].op > 16) begin
            exp_err = 1;
         end else begin
            exp_addr_q.push_back(8'(pc));
            exp_data_q.push_back(model_enc(prog[i]));
            pc++;
            exp_cnt++;
         end
         if (prog[i].last) break;
      end
      d0 = done_seen;
      nacc = 0;
      @(posedge clk); #1;
      base_pc = base;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      chk("err_cleared", 32'(error), 0);
      for (int i = 0; i < prog.size(); i++) begin
         send(prog[i], acc);
         if (!acc) break;
         nacc++;
         if (stall_at == i) stall_left = 3;
         if (prog[i].last) break;
      end
      cmd_vld = 0;
      for (int k = 0; k < 60; k++) begin
         #1;
         if (done_seen != d0) break;
         @(negedge clk);
      end
      chk("done_seen", 32'(done_seen - d0), 1);
      chk("accepted", 32'(nacc), 32'(exp_acc));
      @(posedge clk); #1;
   endtask

   logic [15:0] t2d [5];

   initial begin
      #200000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1);
   end

   initial begin
      bit acc;
      t2d = '{16'h7834, 16'h121A, 16'hC040, 16'hC800, 16'h2D00};
      rst = 0; start = 0; base_pc = 0; cmd_vld = 0; mem_rdy = 1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      cmd_vld = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cmd_rdy", 32'(cmd_rdy), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_addr", 32'(mem_addr), 0);
      chk("rst_wdata", 32'(mem_wdata), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_error", 32'(error), 0);
      rst = 1;

      // Model pins against hand-encoded words.
      chk("model_addi", 32'(model_enc(mk(10, 2, 1, 0, 3, 1, 0, 0, 1))),
          32'h729B);
      chk("model_pop", 32'(model_enc(mk(3, 5, 0, 0, 0, 0, 0, 0, 1))),
          32'h2D00);

      // Single ADDI.
      prog.delete();
      prog.push_back(mk(10, 2, 1, 0, 3, 1, 0, 0, 1));
      run_prog(8'h10, -1);
      chk("t1_n", 32'(log_addr.size()), 1);
      chk("t1_addr", 32'(log_addr[0]), 32'h10);
      chk("t1_data", 32'(log_data[0]), 32'h729B);
      chk("t1_count", 32'(count), 1);

      // Back-to-back stream.
      prog.delete();
      prog.push_back(mk(11, 0, 3, 4, 0, 0, 0, 0, 0));
      prog.push_back(mk(1, 0, 0, 0, 0, 0, 2, 'h1A, 0));
      prog.push_back(mk(13, 0, 0, 0, 0, 0, 0, 'h40, 0));
      prog.push_back(mk(14, 0, 0, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(3, 5, 0, 0, 0, 0, 0, 0, 1));
      run_prog(8'h00, -1);
      chk("t2_n", 32'(log_addr.size()), 5);
      for (int i = 0; i < 5 && i < log_addr.size(); i++) begin
         chk("t2_addr", 32'(log_addr[i]), 32'(i));
         chk("t2_data", 32'(log_data[i]), 32'(t2d[i]));
      end
      chk("t2_rate", 32'(last_hs_cyc - first_hs_cyc), 4);
      chk("t2_count", 32'(count), 5);

      // RAM back-pressure mid-stream.
      prog.delete();
      prog.push_back(mk(7, 1, 0, 0, 6, 0, 0, 0, 0));
      prog.push_back(mk(5, 0, 2, 3, 0, 0, 0, 0, 0));
      prog.push_back(mk(8, 4, 0, 1, 0, 0, 0, 0, 0));
      prog.push_back(mk(16, 0, 0, 0, 0, 0, 0, 0, 1));
      run_prog(8'h80, 1);
      chk("t3_n", 32'(log_addr.size()), 4);
      chk("t3_last", 32'(log_data[log_data.size()-1]), 32'hF800);
      chk("t3_count", 32'(count), 4);

      // Invalid mnemonic between two valid ones.
      prog.delete();
      prog.push_back(mk(7, 1, 0, 0, 5, 0, 0, 0, 0));
      prog.push_back(mk(20, 0, 0, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(9, 3, 1, 2, 0, 1, 0, 0, 1));
      run_prog(8'h30, -1);
      chk("t4_n", 32'(log_addr.size()), 2);
      chk("t4_addr1", 32'(log_addr[1]), 32'h31);
      chk("t4_data1", 32'(log_data[1]), 32'h7392);
      chk("t4_error", 32'(error), 1);

      // Invalid mnemonic carrying last.
      prog.delete();
      prog.push_back(mk(7, 1, 0, 0, 5, 0, 0, 0, 0));
      prog.push_back(mk(31, 0, 0, 0, 0, 0, 0, 0, 1));
      run_prog(8'h50, -1);
      chk("t5_n", 32'(log_addr.size()), 1);
      chk("t5_error", 32'(error), 1);

      // PC overflow at the top of the RAM.
      prog.delete();
      prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(15, 0, 0, 0, 0, 0, 0, 0, 0));
      prog.push_back(mk(16, 0, 0, 0, 0, 0, 0, 0, 1));
      run_prog(8'hFE, -1);
      chk("t6_n", 32'(log_addr.size()), 2);
      chk("t6_addr0", 32'(log_addr[0]), 32'hFE);
      chk("t6_addr1", 32'(log_addr[1]), 32'hFF);
      chk("t6_count", 32'(count), 2);
      chk("t6_error", 32'(error), 1);

      // Reset in the middle of a load with a write pending.
      log_addr.delete();
      @(posedge clk); #1;
      base_pc = 8'h20;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      stall_left = 6;
      send(mk(7, 2, 0, 0, 1, 0, 0, 0, 0), acc);
      chk("t7_acc", 32'(acc), 1);
      chk("t7_pending", 32'(mem_we), 1);
      rst = 0;
      @(posedge clk); #1;
      rst = 1;
      chk("t7_we", 32'(mem_we), 0);
      chk("t7_count", 32'(count), 0);
      chk("t7_rdy", 32'(cmd_rdy), 0);
      chk("t7_error", 32'(error), 0);
      @(posedge clk); #1;
      chk("t7_idle_rdy", 32'(cmd_rdy), 0);
      chk("t7_idle_we", 32'(mem_we), 0);
      cmd_vld = 0;
      repeat (6) @(posedge clk);
      #1;
      chk("t7_nowrite", 32'(log_addr.size()), 0);

      prog.delete();
      prog.push_back(mk(10, 2, 1, 0, 3, 1, 0, 0, 1));
      run_prog(8'h60, -1);
      chk("t8_addr", 32'(log_addr[0]), 32'h60);
      chk("t8_data", 32'(log_data[0]), 32'h729B);
      chk("t8_count", 32'(count), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
